warp_barrier_ctrl: RTL and testbench

Barrier controller for the warp scheduler. It accepts barrier-arrival requests issued by the GPU unit and tracks which warps wait at which barrier ID. When the last expected warp arrives it releases all participants. Its outputs drive the scheduler's barrier stall mask and the warp-release path.

---
 rtl/gpu_types.sv | 37 +++
 rtl/warp_barrier_entry.sv | 64 ++++++
 rtl/warp_barrier_ctrl.sv | 97 +++++++++
 tb/tb_warp_barrier_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_types.sv
// Shared GPU type definitions: core sizing defaults, barrier request and
// barrier release bundles, and the per-barrier state encoding.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_BARRIERS
`define NUM_BARRIERS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NB_BITS
`define NB_BITS 2
`endif
`ifndef GPU_BARRIER_RELEASE_BITS
`define GPU_BARRIER_RELEASE_BITS (1 + `NUM_WARPS)
`endif

package gpu_types;

  typedef struct packed {
    logic                valid;
    logic [`NB_BITS-1:0] id;
    logic [`NW_BITS-1:0] size_m1;
  } gpu_barrier_t;

  typedef struct packed {
    logic                  valid;
    logic [`NUM_WARPS-1:0] wmask;
  } gpu_barrier_release_t;

  typedef enum logic {
    BAR_IDLE       = 1'b0,
    BAR_COLLECTING = 1'b1
  } bar_state_t;

endpackage

// File: rtl/warp_barrier_entry.sv
// One barrier slot: tracks IDLE/COLLECTING state, the waiting-warp mask,
// the arrival count and the participant count latched by the first arrival.
module warp_barrier_entry
  import gpu_types::*;
#(
  parameter int NUM_WARPS = `NUM_WARPS,
  parameter int NW_BITS   = `NW_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arrive,
  input  logic [NW_BITS-1:0]   wid,
  input  logic [NW_BITS-1:0]   size_m1,
  output logic [NUM_WARPS-1:0] mask,
  output logic                 complete,
  output logic [NUM_WARPS-1:0] complete_mask,
  output logic                 size_mismatch
);

  bar_state_t             state;
  logic [NW_BITS:0]       count;
  logic [NW_BITS-1:0]     size_lat;
  logic [NUM_WARPS-1:0]   wid_bit;
  logic [NW_BITS:0]       next_count;
  logic [NW_BITS:0]       target;

  // Decode the arriving warp and decide whether this arrival finishes the barrier;
  // a collecting barrier always uses its latched size, never the request's.
  always_comb begin
    wid_bit        = '0;
    wid_bit[wid]   = 1'b1;
    next_count     = count + (NW_BITS+1)'(1);
    target         = {1'b0, size_lat} + (NW_BITS+1)'(1);
    size_mismatch  = (state == BAR_COLLECTING) && (size_m1 != size_lat);
    complete       = arrive && ((state == BAR_IDLE) ? (size_m1 == '0)
                                                    : (next_count == target));
    complete_mask  = mask | wid_bit;
  end

  // Barrier state machine: start collecting, add members, or complete and clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= BAR_IDLE;
      mask     <= '0;
      count    <= '0;
      size_lat <= '0;
    end else if (arrive) begin
      if (complete) begin
        state <= BAR_IDLE;
        mask  <= '0;
        count <= '0;
      end else if (state == BAR_IDLE) begin
        state    <= BAR_COLLECTING;
        mask     <= wid_bit;
        count    <= (NW_BITS+1)'(1);
        size_lat <= size_m1;
      end else begin
        mask  <= complete_mask;
        count <= next_count;
      end
    end
  end

endmodule

// File: rtl/warp_barrier_ctrl.sv
// Barrier controller for the warp scheduler: decodes arrivals to barrier
// slots, flags protocol violations and holds completed releases in a
// single output slot until the scheduler takes them.
module warp_barrier_ctrl
  import gpu_types::*;
#(
  parameter int NUM_WARPS    = `NUM_WARPS,
  parameter int NUM_BARRIERS = `NUM_BARRIERS,
  parameter int NW_BITS      = `NW_BITS,
  parameter int NB_BITS      = `NB_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bar_valid,
  output logic                 bar_ready,
  input  logic [NW_BITS-1:0]   bar_wid,
  input  logic [NB_BITS-1:0]   bar_id,
  input  logic [NW_BITS-1:0]   bar_size_m1,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic                 release_valid,
  input  logic                 release_ready,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic                 err
);

  logic [NUM_WARPS-1:0]    ent_mask     [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    ent_cmask    [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] ent_complete;
  logic [NUM_BARRIERS-1:0] ent_mismatch;
  logic [NUM_BARRIERS-1:0] ent_arrive;

  logic                    accept;
  logic                    dup;
  logic                    mismatch_sel;
  logic                    complete_any;
  logic [NUM_WARPS-1:0]    complete_sel;

  // A held, unconsumed release blocks new arrivals so the single slot is never overwritten.
  assign bar_ready = reset_n & ~(release_valid & ~release_ready);
  assign accept    = bar_valid & bar_ready;
  assign dup       = stall_mask[bar_wid];

  genvar g;
  generate
    for (g = 0; g < NUM_BARRIERS; g++) begin : g_entry
      assign ent_arrive[g] = accept & ~dup & (bar_id == NB_BITS'(g));

      warp_barrier_entry #(
        .NUM_WARPS (NUM_WARPS),
        .NW_BITS   (NW_BITS)
      ) u_entry (
        .clk           (clk),
        .reset_n       (reset_n),
        .arrive        (ent_arrive[g]),
        .wid           (bar_wid),
        .size_m1       (bar_size_m1),
        .mask          (ent_mask[g]),
        .complete      (ent_complete[g]),
        .complete_mask (ent_cmask[g]),
        .size_mismatch (ent_mismatch[g])
      );
    end
  endgenerate

  // Merge all waiting warps and pick the mask of whichever barrier completes this cycle.
  always_comb begin
    stall_mask   = '0;
    complete_sel = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      stall_mask = stall_mask | ent_mask[i];
      if (ent_complete[i]) begin
        complete_sel = complete_sel | ent_cmask[i];
      end
    end
    complete_any = |ent_complete;
    mismatch_sel = ent_mismatch[bar_id];
  end

  // Output slot and error pulse; a new completion may reload the slot in the cycle it is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      release_valid <= 1'b0;
      release_mask  <= '0;
      err           <= 1'b0;
    end else begin
      err <= accept & (dup | mismatch_sel);
      if (complete_any) begin
        release_valid <= 1'b1;
        release_mask  <= complete_sel;
      end else if (release_ready) begin
        release_valid <= 1'b0;
        release_mask  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_warp_barrier_ctrl.sv
// Directed self-checking bench for warp_barrier_ctrl.
module tb_warp_barrier_ctrl;

  logic       clk;
  logic       reset_n;
  logic       bar_valid;
  logic       bar_ready;
  logic [1:0] bar_wid;
  logic [1:0] bar_id;
  logic [1:0] bar_size_m1;
  logic [3:0] stall_mask;
  logic       release_valid;
  logic       release_ready;
  logic [3:0] release_mask;
  logic       err;

  int totalChecks;
  int badChecks;

  warp_barrier_ctrl #(
    .NUM_WARPS    (4),
    .NUM_BARRIERS (4),
    .NW_BITS      (2),
    .NB_BITS      (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bar_valid     (bar_valid),
    .bar_ready     (bar_ready),
    .bar_wid       (bar_wid),
    .bar_id        (bar_id),
    .bar_size_m1   (bar_size_m1),
    .stall_mask    (stall_mask),
    .release_valid (release_valid),
    .release_ready (release_ready),
    .release_mask  (release_mask),
    .err           (err)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one arrival for one cycle; returns #1 after the accepting edge
  task automatic applyStimulus(input logic [1:0] wid, input logic [1:0] id, input logic [1:0] sm1);
    bar_valid   = 1'b1;
    bar_wid     = wid;
    bar_id      = id;
    bar_size_m1 = sm1;
    @(posedge clk);
    #1;
    bar_valid = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    totalChecks   = 0;
    badChecks     = 0;
    reset_n       = 1'b0;
    bar_valid     = 1'b0;
    bar_wid       = '0;
    bar_id        = '0;
    bar_size_m1   = '0;
    release_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", 32'(stall_mask), 32'h0);
    checkOutput("rst_rvalid", 32'(release_valid), 32'h0);
    checkOutput("rst_rmask", 32'(release_mask), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_ready", 32'(bar_ready), 32'h0);
    reset_n = 1'b1;
    idleCycle();
    checkOutput("post_rst_ready", 32'(bar_ready), 32'h1);

    // Single-warp barrier completes immediately
    applyStimulus(2'd2, 2'd1, 2'd0);
    checkOutput("single_rvalid", 32'(release_valid), 32'h1);
    checkOutput("single_rmask", 32'(release_mask), 32'h4);
    checkOutput("single_stall", 32'(stall_mask), 32'h0);
    checkOutput("single_err", 32'(err), 32'h0);
    idleCycle();
    checkOutput("single_consumed", 32'(release_valid), 32'h0);

    // Four-warp barrier ramp
    applyStimulus(2'd0, 2'd0, 2'd3);
    checkOutput("four_stall0", 32'(stall_mask), 32'h1);
    applyStimulus(2'd1, 2'd0, 2'd3);
    checkOutput("four_stall1", 32'(stall_mask), 32'h3);
    applyStimulus(2'd2, 2'd0, 2'd3);
    checkOutput("four_stall2", 32'(stall_mask), 32'h7);
    checkOutput("four_no_rel", 32'(release_valid), 32'h0);
    applyStimulus(2'd3, 2'd0, 2'd3);
    checkOutput("four_rvalid", 32'(release_valid), 32'h1);
    checkOutput("four_rmask", 32'(release_mask), 32'hF);
    checkOutput("four_stall3", 32'(stall_mask), 32'h0);
    idleCycle();

    // Interleaved barriers 0 and 2
    applyStimulus(2'd0, 2'd0, 2'd1);
    checkOutput("il_stall_a", 32'(stall_mask), 32'h1);
    applyStimulus(2'd2, 2'd2, 2'd1);
    checkOutput("il_stall_b", 32'(stall_mask), 32'h5);
    applyStimulus(2'd1, 2'd0, 2'd1);
    checkOutput("il_rel0_valid", 32'(release_valid), 32'h1);
    checkOutput("il_rel0_mask", 32'(release_mask), 32'h3);
    checkOutput("il_stall_c", 32'(stall_mask), 32'h4);
    applyStimulus(2'd3, 2'd2, 2'd1);
    checkOutput("il_rel1_valid", 32'(release_valid), 32'h1);
    checkOutput("il_rel1_mask", 32'(release_mask), 32'hC);
    checkOutput("il_stall_d", 32'(stall_mask), 32'h0);
    checkOutput("il_err", 32'(err), 32'h0);
    idleCycle();
    checkOutput("il_consumed", 32'(release_valid), 32'h0);

    // Backpressure: held release blocks a pending request which is later taken
    release_ready = 1'b0;
    applyStimulus(2'd1, 2'd3, 2'd0);
    checkOutput("bp_rvalid", 32'(release_valid), 32'h1);
    checkOutput("bp_rmask", 32'(release_mask), 32'h2);
    bar_valid   = 1'b1;
    bar_wid     = 2'd0;
    bar_id      = 2'd1;
    bar_size_m1 = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_ready_low", 32'(bar_ready), 32'h0);
      checkOutput("bp_hold_mask", 32'(release_mask), 32'h2);
    end
    release_ready = 1'b1;
    #1;
    checkOutput("bp_ready_back", 32'(bar_ready), 32'h1);
    @(posedge clk);
    #1;
    bar_valid = 1'b0;
    checkOutput("bp_new_rvalid", 32'(release_valid), 32'h1);
    checkOutput("bp_new_rmask", 32'(release_mask), 32'h1);
    idleCycle();
    checkOutput("bp_drained", 32'(release_valid), 32'h0);

    // Duplicate arrival at barrier 3
    applyStimulus(2'd1, 2'd3, 2'd2);
    checkOutput("dup_stall_a", 32'(stall_mask), 32'h2);
    checkOutput("dup_err_none", 32'(err), 32'h0);
    applyStimulus(2'd1, 2'd3, 2'd2);
    checkOutput("dup_err", 32'(err), 32'h1);
    checkOutput("dup_stall_b", 32'(stall_mask), 32'h2);
    applyStimulus(2'd2, 2'd3, 2'd2);
    checkOutput("dup_err_clear", 32'(err), 32'h0);
    checkOutput("dup_no_rel", 32'(release_valid), 32'h0);
    applyStimulus(2'd3, 2'd3, 2'd2);
    checkOutput("dup_rvalid", 32'(release_valid), 32'h1);
    checkOutput("dup_rmask", 32'(release_mask), 32'hE);
    idleCycle();

    // Size mismatch: latched 2, second arrival claims 1
    applyStimulus(2'd0, 2'd1, 2'd2);
    checkOutput("sz_stall_a", 32'(stall_mask), 32'h1);
    applyStimulus(2'd1, 2'd1, 2'd1);
    checkOutput("sz_err", 32'(err), 32'h1);
    checkOutput("sz_stall_b", 32'(stall_mask), 32'h3);
    checkOutput("sz_no_rel", 32'(release_valid), 32'h0);
    applyStimulus(2'd2, 2'd1, 2'd2);
    checkOutput("sz_rvalid", 32'(release_valid), 32'h1);
    checkOutput("sz_rmask", 32'(release_mask), 32'h7);
    checkOutput("sz_err_clear", 32'(err), 32'h0);
    idleCycle();

    // Reset in the middle of collection
    applyStimulus(2'd0, 2'd0, 2'd3);
    applyStimulus(2'd1, 2'd0, 2'd3);
    checkOutput("mr_stall_pre", 32'(stall_mask), 32'h3);
    reset_n = 1'b0;
    #1;
    checkOutput("mr_stall_rst", 32'(stall_mask), 32'h0);
    checkOutput("mr_ready_rst", 32'(bar_ready), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("mr_no_rel", 32'(release_valid), 32'h0);
      checkOutput("mr_stall_zero", 32'(stall_mask), 32'h0);
    end
    applyStimulus(2'd3, 2'd0, 2'd0);
    checkOutput("mr_fresh_rvalid", 32'(release_valid), 32'h1);
    checkOutput("mr_fresh_rmask", 32'(release_mask), 32'h8);
    idleCycle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
